carry_chain_seq: RTL and testbench

//  Sequences one DSP48A1 slice through a multi-word (up to MAX_WORDS x 48b) add.

---
 rtl/carry_chain_seq_if.sv | 50 +++++
 rtl/carry_chain_seq.sv | 167 ++++++++++++++++
 tb/tb_carry_chain_seq.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/carry_chain_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : carry_chain_seq_if
// Purpose  : Operand-stream / DSP48A1 slice control bundle of carry_chain_seq.
//            ABORT exists only when CARRY_SEQ_ABORT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface carry_chain_seq_if #(
  parameter int CNT_W = 3
);
  logic             start;
  logic [CNT_W-1:0] nwords;
  logic             carry_init;
  logic             in_valid;
  logic             in_ready;
  logic             slice_ce;
  logic             slice_carryin;
  logic             slice_cecarryin;
  logic             slice_rstcarryin;
  logic             slice_carryout;
  logic             out_valid;
  logic             out_last;
  logic [CNT_W-1:0] word_idx;
  logic             busy;
  logic             done;
  logic             carry_final;
`ifdef CARRY_SEQ_ABORT_EN
  logic             abort;
`endif

  // master: operand source plus slice; slave: the sequencer
  modport master (
    output start, nwords, carry_init, in_valid, slice_carryout,
`ifdef CARRY_SEQ_ABORT_EN
    output abort,
`endif
    input  in_ready, slice_ce, slice_carryin, slice_cecarryin, slice_rstcarryin,
    input  out_valid, out_last, word_idx, busy, done, carry_final
  );

  modport slave (
    input  start, nwords, carry_init, in_valid, slice_carryout,
`ifdef CARRY_SEQ_ABORT_EN
    input  abort,
`endif
    output in_ready, slice_ce, slice_carryin, slice_cecarryin, slice_rstcarryin,
    output out_valid, out_last, word_idx, busy, done, carry_final
  );
endinterface
`default_nettype wire

// File: rtl/carry_chain_seq.sv
`default_nettype none
// ============================================================================
// Module   : carry_chain_seq
// Purpose  : Walks one DSP48A1 slice through a multi-word add, chaining
//            CARRYOUT back into CARRYIN. Optional ABORT: CARRY_SEQ_ABORT_EN.
// Revision : 1.0  initial release
// ============================================================================
module carry_chain_seq #(
  parameter int MAX_WORDS = 4,
  parameter int CNT_W     = 3,
  parameter int PIPE_LAT  = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  carry_chain_seq_if.slave bus_if
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_WORDS);
  localparam logic [3:0]       WAIT_LOAD = 4'(PIPE_LAT - 1);

  logic [1:0]       rst_sync_q;
  logic             rst_n_sync;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] word_idx_q, word_idx_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic             carryin_q, carryin_d;
  logic             cecarryin_q, cecarryin_d;
  logic             rstcarryin_q, rstcarryin_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             carry_final_q, carry_final_d;
  logic             abort_w;
  logic             last_w;
  logic             handshake_w;
  logic [CNT_W-1:0] nwords_clamped_w;

  // Asynchronous assertion, release retimed to clk_i
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_sync = rst_sync_q[1];

`ifdef CARRY_SEQ_ABORT_EN
  assign abort_w = bus_if.abort & (state_q != S_IDLE);
`else
  assign abort_w = 1'b0;
`endif

  assign bus_if.in_ready = (state_q == S_ISSUE) & ~abort_w;
  assign bus_if.slice_ce = bus_if.in_ready & bus_if.in_valid;
  assign handshake_w     = bus_if.slice_ce;
  assign last_w          = (word_idx_q == count_q - CNT_W'(1));

  assign nwords_clamped_w = (bus_if.nwords == '0)     ? CNT_W'(1) :
                            (bus_if.nwords > MAX_CNT) ? MAX_CNT   : bus_if.nwords;

  always_ff @(posedge clk_i or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      word_idx_q    <= '0;
      wait_cnt_q    <= '0;
      carryin_q     <= 1'b0;
      cecarryin_q   <= 1'b0;
      rstcarryin_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      carry_final_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      word_idx_q    <= word_idx_d;
      wait_cnt_q    <= wait_cnt_d;
      carryin_q     <= carryin_d;
      cecarryin_q   <= cecarryin_d;
      rstcarryin_q  <= rstcarryin_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      carry_final_q <= carry_final_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus_if.start) state_d = S_INIT;
      S_INIT:    state_d = S_ISSUE;
      S_ISSUE:   if (handshake_w) state_d = (PIPE_LAT == 1) ? S_CAPTURE : S_WAIT;
      S_WAIT:    if (wait_cnt_q == 4'd1) state_d = S_CAPTURE;
      S_CAPTURE: state_d = last_w ? S_DONE : S_ISSUE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort_w) state_d = S_IDLE;
  end

  // Registered outputs are decoded from state_d so they line up with the state they describe
  always_comb begin
    count_d       = count_q;
    word_idx_d    = word_idx_q;
    wait_cnt_d    = wait_cnt_q;
    carry_final_d = carry_final_q;
    carryin_d     = 1'b0;
    cecarryin_d   = 1'b0;
    rstcarryin_d  = 1'b0;
    case (state_q)
      S_IDLE: if (state_d == S_INIT) begin
        count_d       = nwords_clamped_w;
        word_idx_d    = '0;
        carry_final_d = 1'b0;
        carryin_d     = bus_if.carry_init;
        cecarryin_d   = bus_if.carry_init;
        rstcarryin_d  = ~bus_if.carry_init;
      end
      S_ISSUE: if (handshake_w) wait_cnt_d = WAIT_LOAD;
      S_WAIT:  wait_cnt_d = wait_cnt_q - 4'd1;
      S_CAPTURE: begin
        if (last_w) begin
          carry_final_d = bus_if.slice_carryout;
        end else begin
          carryin_d   = bus_if.slice_carryout;
          cecarryin_d = 1'b1;
          word_idx_d  = word_idx_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    if (abort_w) begin
      carry_final_d = carry_final_q;
      word_idx_d    = word_idx_q;
      carryin_d     = 1'b0;
      cecarryin_d   = 1'b0;
      rstcarryin_d  = 1'b1;
    end
    out_valid_d = (state_d == S_CAPTURE);
    out_last_d  = (state_d == S_CAPTURE) && (word_idx_d == count_d - CNT_W'(1));
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  assign bus_if.slice_carryin    = carryin_q;
  assign bus_if.slice_cecarryin  = cecarryin_q;
  assign bus_if.slice_rstcarryin = rstcarryin_q;
  assign bus_if.out_valid        = out_valid_q;
  assign bus_if.out_last         = out_last_q;
  assign bus_if.word_idx         = word_idx_q;
  assign bus_if.busy             = busy_q;
  assign bus_if.done             = done_q;
  assign bus_if.carry_final      = carry_final_q;

endmodule
`default_nettype wire

// File: tb/tb_carry_chain_seq.sv
`default_nettype none
// Bench for carry_chain_seq: plays operand source and DSP slice, compares
// against wide-integer addition of the random operand words.
module tb_carry_chain_seq;
  localparam int PL = 2;
  localparam int MW = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  carry_chain_seq_if #(.CNT_W(CW)) bus ();
  carry_chain_seq #(.MAX_WORDS(MW), .CNT_W(CW), .PIPE_LAT(PL)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus_if  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [47:0] op_a [8];
  logic [47:0] op_b [8];
  int op_id = 0;

  // Slice model: carry-in register plus PIPE_LAT-deep result delay
  int seen_op = 0;
  int issue_cnt = 0;
  int delay = 0;
  int viol = 0;
  logic cin_reg = 1'b0;
  logic co_pend = 1'b0;
  logic [48:0] sum;

  always @(negedge clk) begin
    if (!rst_n) begin
      cin_reg = 1'b0;
      delay = 0;
      issue_cnt = 0;
    end else begin
      if (op_id != seen_op) begin
        seen_op = op_id;
        issue_cnt = 0;
      end
      if (bus.slice_rstcarryin && bus.slice_cecarryin) viol++;
      if (bus.slice_rstcarryin) cin_reg = 1'b0;
      else if (bus.slice_cecarryin) cin_reg = bus.slice_carryin;
      if (bus.slice_ce) begin
        sum = {1'b0, op_a[issue_cnt]} + {1'b0, op_b[issue_cnt]} + 49'(cin_reg);
        co_pend = sum[48];
        delay = PL;
        if (issue_cnt < 7) issue_cnt++;
      end else if (delay != 0) begin
        delay--;
      end
    end
  end

  // Carry-out is only correct in the cycle it is due; otherwise its complement
  always @(posedge clk) begin
    #1;
    bus.slice_carryout = (delay == 1) ? co_pend : ~co_pend;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [199:0] A, B, S;

  task automatic load_ops(input int cnt, input bit ci);
    logic [63:0] r;
    A = '0;
    B = '0;
    for (int i = 0; i < 8; i++) begin
      r = {$urandom, $urandom};
      op_a[i] = r[47:0];
      r = {$urandom, $urandom};
      op_b[i] = ($urandom_range(0, 1) == 1) ? ~op_a[i] : r[47:0];
      if (i < cnt) begin
        A[i*48 +: 48] = op_a[i];
        B[i*48 +: 48] = op_b[i];
      end
    end
    S = A + B + 200'(ci);
    op_id++;
  endtask

  task automatic run_op(input int nw, input bit ci, input int stall_word,
                        input int stall_len, input bit busy_start);
    int cnt, k, n_out, done_k, stall_rem, exp_stall, wt, viol0;
    bit stalled;
    logic [47:0] dummy;
    cnt = (nw == 0) ? 1 : ((nw > MW) ? MW : nw);
    exp_stall = (stall_word < cnt) ? stall_len : 0;
    wt = 0;
    while (bus.busy !== 1'b0 && wt < 50) begin step(); wt++; end
    chk("idle_before_start", 64'(bus.busy), 64'(0));
    load_ops(cnt, ci);
    viol0 = viol;
    bus.start = 1'b1;
    bus.nwords = CW'(nw);
    bus.carry_init = ci;
    bus.in_valid = 1'b0;
    k = 0; n_out = 0; done_k = -1; stall_rem = stall_len;
    while (k < 300) begin
      step();
      k++;
      bus.start = (busy_start && k == 4);
      stalled = (bus.in_ready === 1'b1 && bus.word_idx == CW'(stall_word) && stall_rem > 0);
      if (stalled) begin bus.in_valid = 1'b0; stall_rem--; end
      else bus.in_valid = 1'b1;
      #1;
      if (k == 1) begin
        chk("init_rstcarryin", 64'(bus.slice_rstcarryin), 64'(!ci));
        chk("init_cecarryin", 64'(bus.slice_cecarryin), 64'(ci));
        if (ci) chk("init_carryin", 64'(bus.slice_carryin), 64'(1));
        chk("init_in_ready", 64'(bus.in_ready), 64'(0));
        chk("init_busy", 64'(bus.busy), 64'(1));
      end
      if (stalled) begin
        chk("stall_in_ready", 64'(bus.in_ready), 64'(1));
        chk("stall_slice_ce", 64'(bus.slice_ce), 64'(0));
        chk("stall_word_idx", 64'(bus.word_idx), 64'(stall_word));
      end
      if (bus.slice_cecarryin === 1'b1 && k > 1)
        chk("fed_back_carry", 64'(bus.slice_carryin),
            64'(S[48*n_out] ^ A[48*n_out] ^ B[48*n_out]));
      if (bus.out_valid === 1'b1) begin
        chk("out_word_idx", 64'(bus.word_idx), 64'(n_out));
        chk("out_last", 64'(bus.out_last), 64'(n_out == cnt - 1));
        n_out++;
      end
      if (bus.done === 1'b1) begin done_k = k; break; end
    end
    chk("done_latency", 64'(done_k), 64'(2 + cnt * (PL + 1) + exp_stall));
    chk("out_valid_count", 64'(n_out), 64'(cnt));
    chk("carry_final", 64'(bus.carry_final), 64'(S[48*cnt]));
    chk("busy_in_done", 64'(bus.busy), 64'(1));
    chk("rst_ce_exclusive", 64'(viol), 64'(viol0));
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("idle_after_done", 64'({bus.busy, bus.done}), 64'(0));
    chk("carry_final_hold", 64'(bus.carry_final), 64'(S[48*cnt]));
    step();
    #1;
    chk("start_in_done_ignored", 64'(bus.busy), 64'(0));
    dummy = 48'(0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.nwords = '0;
    bus.carry_init = 1'b0;
    bus.in_valid = 1'b0;
`ifdef CARRY_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({bus.in_ready, bus.slice_ce, bus.slice_carryin, bus.slice_cecarryin,
                              bus.slice_rstcarryin, bus.out_valid, bus.out_last, bus.word_idx,
                              bus.busy, bus.done, bus.carry_final}), 64'(0));
    step();
    rst_n = 1'b1;
    repeat (4) step();

    run_op(3, 1'b0, 9, 0, 1'b0);
    run_op(1, 1'b1, 9, 0, 1'b0);
    run_op(2, 1'b0, 1, 5, 1'b1);
    run_op(0, 1'b1, 9, 0, 1'b0);
    run_op(7, 1'b0, 9, 0, 1'b0);
    for (int i = 0; i < 8; i++)
      run_op($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             $urandom_range(0, 4), 1'($urandom_range(0, 1)));

    // Asynchronous reset in the WAIT state of word 0
    load_ops(3, 1'b0);
    bus.start = 1'b1;
    bus.nwords = CW'(3);
    bus.carry_init = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      bus.start = 1'b0;
      bus.in_valid = 1'b1;
    end
    #1;
    chk("busy_before_reset", 64'(bus.busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({bus.in_ready, bus.slice_ce, bus.slice_carryin,
                                    bus.slice_cecarryin, bus.slice_rstcarryin, bus.out_valid,
                                    bus.out_last, bus.word_idx, bus.busy, bus.done,
                                    bus.carry_final}), 64'(0));
    bus.in_valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("idle_after_reset", 64'({bus.busy, bus.in_ready}), 64'(0));
    run_op(2, 1'b1, 0, 2, 1'b0);

`ifdef CARRY_SEQ_ABORT_EN
    begin
      int seen;
      load_ops(3, 1'b0);
      bus.start = 1'b1;
      bus.nwords = CW'(3);
      bus.carry_init = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        step();
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
      end
      #1;
      chk("abort_word_idx", 64'(bus.word_idx), 64'(1));
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("abort_idle", 64'({bus.busy, bus.in_ready}), 64'(0));
      chk("abort_rstcarryin", 64'(bus.slice_rstcarryin), 64'(1));
      chk("abort_no_out", 64'({bus.out_valid, bus.done, bus.carry_final}), 64'(0));
      seen = 0;
      for (int k = 0; k < 12; k++) begin
        step();
        if (bus.done === 1'b1 || bus.out_valid === 1'b1 || bus.busy === 1'b1) seen++;
      end
      chk("abort_stays_idle", 64'(seen), 64'(0));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
